// File: rtl/leaf_pkg.sv
// rtl/leaf_pkg.sv - shared packet field widths, offsets and types for the leaf output lane
package leaf_pkg;

    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;
    localparam int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;

    localparam int CREDIT_BITS = 8;
    localparam int CREDIT_INIT = 64;

    localparam int ADDR_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB  = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB  = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT = PACKET_BITS - 1;

    typedef logic [CREDIT_BITS-1:0] credit_t;

    typedef struct packed {
        logic                     valid;
        logic [NUM_LEAF_BITS-1:0] dest_leaf;
        logic [NUM_PORT_BITS-1:0] dest_port;
        logic [NUM_ADDR_BITS-1:0] seq_addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } packet_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after ptr, ascending with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (en && !any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// rtl/leaf_out_arbiter.sv - credit-gated round-robin merge of user streams onto one BFT packet lane
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  ap_start,
    input  logic                                  cfg_we,
    input  logic [2:0]                            cfg_sel,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_dest_port,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user,
    output logic [NUM_OUT_PORTS-1:0]              ack_user,
    input  logic                                  credit_vld,
    input  logic [2:0]                            credit_sel,
    input  logic [CREDIT_BITS-1:0]                credit_amt,
    input  logic                                  bft_ready,
    output logic [PACKET_BITS-1:0]                dout_pkt
);

    localparam int IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam logic [CREDIT_BITS:0] CREDIT_ONE = 1;

    arb_state_t state, state_nxt;
    logic       run_en;

    credit_t                  credit     [NUM_OUT_PORTS];
    credit_t                  credit_nxt [NUM_OUT_PORTS];
    logic [CREDIT_BITS:0]     credit_sum [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq        [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dest_leaf  [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port  [NUM_OUT_PORTS];

    logic [NUM_OUT_PORTS-1:0] cfg_valid;
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_any;
    logic                     slot_free;
    packet_t                  pkt_q;
    packet_t                  pkt_next;

    always_comb begin
        state_nxt = state;
        run_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ap_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Dropping ap_start stops grants this cycle; a pending packet still drains.
                run_en = ap_start;
                if (!ap_start) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user[i] & cfg_valid[i] & (credit[i] != '0);
        end
    end

    assign slot_free = !dout_pkt[VALID_BIT] | bft_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_OUT_PORTS),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (eligible),
        .en        (run_en & slot_free),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign ack_user = grant;
    assign dout_pkt = pkt_q;

    always_comb begin
        pkt_next = '0;
        if (grant_any) begin
            pkt_next.valid     = 1'b1;
            pkt_next.dest_leaf = dest_leaf[grant_idx];
            pkt_next.dest_port = dest_port[grant_idx];
            pkt_next.seq_addr  = seq[grant_idx];
            pkt_next.payload   = din_user[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // One extra bit of headroom so a grant plus a return can be saturated after the sum.
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_sum[i] = {1'b0, credit[i]};
            if (grant[i]) credit_sum[i] = credit_sum[i] - CREDIT_ONE;
            if (credit_vld && (int'(credit_sel) == i)) credit_sum[i] = credit_sum[i] + {1'b0, credit_amt};
            credit_nxt[i] = credit_sum[i][CREDIT_BITS] ? '1 : credit_sum[i][CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            pkt_q     <= '0;
            cfg_valid <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i]    <= CREDIT_BITS'(CREDIT_INIT);
                seq[i]       <= '0;
                dest_leaf[i] <= '0;
                dest_port[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (slot_free) pkt_q <= pkt_next;
            if (grant_any) begin
                rr_ptr <= (grant_idx == IDX_W'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
                if (grant[i]) seq[i] <= seq[i] + NUM_ADDR_BITS'(1);
                if (cfg_we && (int'(cfg_sel) == i)) begin
                    dest_leaf[i] <= cfg_dest_leaf;
                    dest_port[i] <= cfg_dest_port;
                    cfg_valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb/tb_leaf_out_arbiter.sv - self-checking bench for leaf_out_arbiter
module tb_leaf_out_arbiter;

    logic        clk;
    logic        reset;
    logic        ap_start;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [4:0]  cfg_dest_leaf;
    logic [3:0]  cfg_dest_port;
    logic [63:0] din_user;
    logic [1:0]  vld_user;
    logic [1:0]  ack_user;
    logic        credit_vld;
    logic [2:0]  credit_sel;
    logic [7:0]  credit_amt;
    logic        bft_ready;
    logic [48:0] dout_pkt;

    leaf_out_arbiter #(.NUM_OUT_PORTS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_dest_leaf (cfg_dest_leaf),
        .cfg_dest_port (cfg_dest_port),
        .din_user      (din_user),
        .vld_user      (vld_user),
        .ack_user      (ack_user),
        .credit_vld    (credit_vld),
        .credit_sel    (credit_sel),
        .credit_amt    (credit_amt),
        .bft_ready     (bft_ready),
        .dout_pkt      (dout_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        ap;
        logic        we;
        logic [2:0]  csel;
        logic [4:0]  leaf;
        logic [3:0]  port;
        logic [1:0]  vld;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        bft;
        logic [1:0]  eack;
        logic [48:0] edout;
    } vec_t;

    vec_t vecs [14];

    // Reference model: per-stream counters as plain integers.
    int          m_credit [2];
    int          m_seq    [2];
    int          m_leaf   [2];
    int          m_port   [2];
    bit          m_cfgv   [2];
    int          m_ptr;
    bit          m_run;
    logic [48:0] m_pkt;

    int acks0, acks1;
    bit track_seq;
    bit wrap_seen;
    int last_seq;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [48:0] pk(input int leaf, input int port, input int seqv, input logic [31:0] d);
        return {1'b1, 5'(leaf), 4'(port), 7'(seqv), d};
    endfunction

    function automatic vec_t mkv(input logic ap, input logic we, input int csel, input int leaf, input int port,
                                 input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic bft, input logic [1:0] eack, input logic [48:0] edout);
        vec_t v;
        v.ap = ap; v.we = we; v.csel = 3'(csel); v.leaf = 5'(leaf); v.port = 4'(port);
        v.vld = vld; v.d0 = d0; v.d1 = d1; v.bft = bft; v.eack = eack; v.edout = edout;
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_credit[s] = 64; m_seq[s] = 0; m_leaf[s] = 0; m_port[s] = 0; m_cfgv[s] = 0;
        end
        m_ptr = 0; m_run = 0; m_pkt = '0;
    endtask

    function automatic int model_grant();
        bit free;
        int s;
        free = !m_pkt[48] || bft_ready;
        if (!(m_run && ap_start && free)) return -1;
        for (int k = 0; k < 2; k++) begin
            s = (m_ptr + k) % 2;
            if (vld_user[s] && m_cfgv[s] && m_credit[s] > 0) return s;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        int c;
        if (!m_pkt[48] || bft_ready) begin
            if (g >= 0) m_pkt = pk(m_leaf[g], m_port[g], m_seq[g], din_user[g*32 +: 32]);
            else        m_pkt = '0;
        end
        if (g >= 0) begin
            m_seq[g] = (m_seq[g] + 1) % 128;
            m_ptr    = (g + 1) % 2;
        end
        for (int s = 0; s < 2; s++) begin
            c = m_credit[s];
            if (g == s) c = c - 1;
            if (credit_vld && int'(credit_sel) == s) c = c + int'(credit_amt);
            m_credit[s] = (c > 255) ? 255 : c;
        end
        if (cfg_we && int'(cfg_sel) < 2) begin
            m_leaf[cfg_sel[0]] = int'(cfg_dest_leaf);
            m_port[cfg_sel[0]] = int'(cfg_dest_port);
            m_cfgv[cfg_sel[0]] = 1'b1;
        end
        m_run = ap_start;
    endtask

    // Inputs are driven just after a rising edge; outputs are compared mid-cycle.
    task automatic cycle(input string tag);
        int g;
        #4;
        g = model_grant();
        check({tag, " ack"}, 64'(ack_user), (g >= 0) ? (64'(1) << g) : 64'(0));
        check({tag, " dout"}, 64'(dout_pkt), 64'(m_pkt));
        if (ack_user[0]) acks0++;
        if (ack_user[1]) acks1++;
        if (track_seq && dout_pkt[48]) begin
            if (last_seq == 127 && int'(dout_pkt[38:32]) == 0) wrap_seen = 1'b1;
            last_seq = int'(dout_pkt[38:32]);
        end
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_we = 0; cfg_sel = 0; cfg_dest_leaf = 0; cfg_dest_port = 0;
        din_user = '0; vld_user = 0; credit_vld = 0; credit_sel = 0; credit_amt = 0;
    endtask

    initial begin
        reset = 0; ap_start = 0; bft_ready = 1;
        idle_inputs();
        track_seq = 0; wrap_seen = 0; last_seq = -1;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout", 64'(dout_pkt), 64'(0));
        check("reset ack", 64'(ack_user), 64'(0));

        vecs[0]  = mkv(1, 1, 0, 3, 2, 2'b00, 32'h0, 32'h0, 1, 2'b00, 49'h0);
        vecs[1]  = mkv(1, 0, 0, 0, 0, 2'b01, 32'hA5A5A5A5, 32'h0, 1, 2'b01, 49'h0);
        vecs[2]  = mkv(1, 0, 0, 0, 0, 2'b01, 32'h11111111, 32'h0, 0, 2'b00, pk(3, 2, 0, 32'hA5A5A5A5));
        vecs[3]  = mkv(1, 0, 0, 0, 0, 2'b01, 32'h11111111, 32'h0, 0, 2'b00, pk(3, 2, 0, 32'hA5A5A5A5));
        vecs[4]  = mkv(1, 0, 0, 0, 0, 2'b01, 32'h12345678, 32'h0, 1, 2'b01, pk(3, 2, 0, 32'hA5A5A5A5));
        vecs[5]  = mkv(1, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, pk(3, 2, 1, 32'h12345678));
        vecs[6]  = mkv(1, 1, 1, 7, 9, 2'b10, 32'h0, 32'hCAFE0001, 1, 2'b00, 49'h0);
        vecs[7]  = mkv(1, 0, 0, 0, 0, 2'b11, 32'hAAAA0000, 32'hBBBB0000, 1, 2'b10, 49'h0);
        vecs[8]  = mkv(1, 0, 0, 0, 0, 2'b11, 32'hAAAA0000, 32'hBBBB0000, 1, 2'b01, pk(7, 9, 0, 32'hBBBB0000));
        vecs[9]  = mkv(1, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, pk(3, 2, 2, 32'hAAAA0000));
        vecs[10] = mkv(1, 1, 0, 31, 15, 2'b01, 32'hC0DE0001, 32'h0, 1, 2'b01, 49'h0);
        vecs[11] = mkv(1, 0, 0, 0, 0, 2'b01, 32'hC0DE0002, 32'h0, 1, 2'b01, pk(3, 2, 3, 32'hC0DE0001));
        vecs[12] = mkv(1, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 2'b00, pk(31, 15, 4, 32'hC0DE0002));
        vecs[13] = mkv(0, 0, 0, 0, 0, 2'b01, 32'h0, 32'h0, 1, 2'b00, 49'h0);

        reset = 1;
        for (int r = 0; r < 14; r++) begin
            ap_start = vecs[r].ap; cfg_we = vecs[r].we; cfg_sel = vecs[r].csel;
            cfg_dest_leaf = vecs[r].leaf; cfg_dest_port = vecs[r].port;
            vld_user = vecs[r].vld; din_user = {vecs[r].d1, vecs[r].d0}; bft_ready = vecs[r].bft;
            #4;
            check($sformatf("row%0d ack", r), 64'(ack_user), 64'(vecs[r].eack));
            check($sformatf("row%0d dout", r), 64'(dout_pkt), 64'(vecs[r].edout));
            @(posedge clk);
            #1;
        end

        idle_inputs();
        ap_start = 0; bft_ready = 1;
        reset = 0;
        @(posedge clk);
        #1;
        reset = 1;
        model_reset();

        ap_start = 1;
        cfg_we = 1; cfg_sel = 0; cfg_dest_leaf = 3; cfg_dest_port = 2;
        cycle("cfg0");
        cfg_sel = 1; cfg_dest_leaf = 7; cfg_dest_port = 9;
        cycle("cfg1");
        cfg_we = 0;

        vld_user = 2'b01; acks0 = 0;
        repeat (66) begin
            din_user = {$urandom, $urandom};
            cycle("exhaust");
        end
        check("s0 grants until credit empty", 64'(acks0), 64'(64));

        vld_user = 2'b11; acks0 = 0; acks1 = 0;
        repeat (4) cycle("empty s0");
        check("s0 grants at zero credit", 64'(acks0), 64'(0));
        check("s1 grants while s0 empty", 64'(acks1), 64'(4));

        vld_user = 2'b00; credit_vld = 1; credit_sel = 0; credit_amt = 4;
        cycle("credit4");
        credit_vld = 0; vld_user = 2'b01; acks0 = 0;
        repeat (8) cycle("refill");
        check("s0 grants after 4 credits", 64'(acks0), 64'(4));

        vld_user = 2'b00; credit_vld = 1; credit_sel = 0; credit_amt = 100;
        cycle("credit100");
        credit_vld = 0; vld_user = 2'b11; acks0 = 0; acks1 = 0;
        repeat (10) begin
            din_user = {$urandom, $urandom};
            cycle("alternate");
        end
        check("alternate s0 count", 64'(acks0), 64'(5));
        check("alternate s1 count", 64'(acks1), 64'(5));

        vld_user = 2'b10; credit_vld = 1; credit_sel = 1; credit_amt = 1;
        track_seq = 1; last_seq = -1;
        repeat (135) begin
            din_user = {$urandom, $urandom};
            cycle("seq wrap");
        end
        track_seq = 0; credit_vld = 0;
        check("seq wrap 127 to 0 seen", 64'(wrap_seen), 64'(1));

        repeat (200) begin
            ap_start      = ($urandom_range(0, 9) != 0);
            bft_ready     = $urandom_range(0, 1);
            vld_user      = 2'($urandom_range(0, 3));
            din_user      = {$urandom, $urandom};
            credit_vld    = ($urandom_range(0, 3) == 0);
            credit_sel    = 3'($urandom_range(0, 3));
            credit_amt    = 8'($urandom_range(0, 255));
            cfg_we        = ($urandom_range(0, 15) == 0);
            cfg_sel       = 3'($urandom_range(0, 3));
            cfg_dest_leaf = 5'($urandom_range(0, 31));
            cfg_dest_port = 4'($urandom_range(0, 15));
            cycle("random");
        end

        idle_inputs();
        ap_start = 1; bft_ready = 1;
        credit_vld = 1; credit_sel = 0; credit_amt = 200;
        cycle("prep");
        credit_vld = 0; vld_user = 2'b11;
        repeat (3) cycle("prep run");
        bft_ready = 0;
        #2;
        check("dout valid before reset", 64'(dout_pkt[48]), 64'(1));
        reset = 0;
        #1;
        check("async reset dout", 64'(dout_pkt), 64'(0));
        check("async reset ack", 64'(ack_user), 64'(0));
        @(posedge clk);
        #1;
        reset = 1; bft_ready = 1;
        model_reset();
        acks0 = 0; acks1 = 0;
        repeat (4) cycle("unconfigured");
        check("grants before reconfig", 64'(acks0 + acks1), 64'(0));
        cfg_we = 1; cfg_sel = 1; cfg_dest_leaf = 2; cfg_dest_port = 1;
        cycle("reconfig");
        cfg_we = 0;
        repeat (4) cycle("after reconfig");
        check("s1 grants after reconfig", 64'(acks1), 64'(4));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
